// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared ALU arbiter types, ALU_Control group encodings and defaults
package alu_share_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_CTRL_WIDTH = 6;

   // ALU_Control[4:3] operation groups
   localparam logic [1:0] ALU_GRP_LOGIC  = 2'b00;
   localparam logic [1:0] ALU_GRP_ARITH  = 2'b01;
   localparam logic [1:0] ALU_GRP_BRANCH = 2'b10;
   localparam logic [1:0] ALU_GRP_PASS   = 2'b11;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   function automatic logic branch_taken(input logic [1:0] grp, input logic res_lsb);
      case (grp)
         ALU_GRP_BRANCH:                            return res_lsb;
         ALU_GRP_LOGIC, ALU_GRP_ARITH, ALU_GRP_PASS: return 1'b0;
         default:                                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant, grant index and owned pointer
module rr_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int ID_WIDTH = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NUM_REQ-1:0]  req,
   input  logic                enable,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx,
   output logic [ID_WIDTH-1:0] ptr
);

   logic                any_grant;
   logic [ID_WIDTH-1:0] ptr_nxt;

   // Scan starting at ptr; first valid requester in rotated order wins.
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (j == idx && req[j] && enable && !any_grant) begin
               any_grant = 1'b1;
               grant[j]  = 1'b1;
               grant_idx = ID_WIDTH'(j);
            end
         end
      end
   end

   assign ptr_nxt = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (any_grant) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU among requesters, registers the result
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*CTRL_WIDTH-1:0] req_ctrl,
   input  logic [NUM_REQ-1:0]            req_branch_op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
   output logic [CTRL_WIDTH-1:0]         alu_ctrl,
   output logic                          alu_branch_op,
   output logic [DATA_WIDTH-1:0]         alu_op_a,
   output logic [DATA_WIDTH-1:0]         alu_op_b,
   input  logic [DATA_WIDTH-1:0]         alu_result,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic                          rsp_taken
);

   rsp_state_e          state, state_nxt;
   logic                can_accept;
   logic                arb_enable;
   logic                any_grant;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_WIDTH-1:0] grant_idx;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] sel_idx;

   assign rsp_valid  = (state == RSP_FULL);
   assign can_accept = !rsp_valid || rsp_ready;
   // Gating with reset_n keeps req_ready low for the whole reset window.
   assign arb_enable = can_accept && reset_n;
   assign any_grant  = |grant;
   assign req_ready  = grant;
   assign sel_idx    = any_grant ? grant_idx : rr_ptr;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_arbiter (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req_valid),
      .enable    (arb_enable),
      .grant     (grant),
      .grant_idx (grant_idx),
      .ptr       (rr_ptr)
   );

   // With no grant the ALU still sees the requester at the pointer, never X.
   always_comb begin
      alu_ctrl      = req_ctrl[CTRL_WIDTH-1:0];
      alu_branch_op = req_branch_op[0];
      alu_op_a      = req_op_a[DATA_WIDTH-1:0];
      alu_op_b      = req_op_b[DATA_WIDTH-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_WIDTH'(i) == sel_idx) begin
            alu_ctrl      = req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
            alu_branch_op = req_branch_op[i];
            alu_op_a      = req_op_a[i*DATA_WIDTH +: DATA_WIDTH];
            alu_op_b      = req_op_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RSP_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RSP_EMPTY: if (any_grant) state_nxt = RSP_FULL;
         RSP_FULL: begin
            if (any_grant)      state_nxt = RSP_FULL;
            else if (rsp_ready) state_nxt = RSP_EMPTY;
         end
         default:   state_nxt = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_taken  <= 1'b0;
      end else if (any_grant) begin
         rsp_id     <= grant_idx;
         rsp_result <= alu_result;
         rsp_taken  <= branch_taken(alu_ctrl[4:3], alu_result[0]);
      end
   end

endmodule
